// File: rtl/rv_plic_gateway_pkg.sv
// Shared types and default constants for the PLIC interrupt gateway.
// The gateway turns raw interrupt lines into pending/active requests
// toward the PLIC target logic, one independent channel per source.
package rv_plic_gateway_pkg;

  // Per-source gateway state:
  //   IDLE    - nothing forwarded, ready to accept a new request
  //   PENDING - request forwarded, waiting for the target to claim it
  //   ACTIVE  - claimed, in service until the target signals completion
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  // Default sizing of the gateway.
  localparam int unsigned DEF_N_SOURCE    = 32;
  localparam int unsigned DEF_CNT_W       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/rv_plic_gateway_chan.sv
// One gateway channel: input synchronizer, rising-edge detector,
// saturating edge counter with sticky overflow, and the
// IDLE/PENDING/ACTIVE handshake with the target's claim/complete pulses.
module rv_plic_gateway_chan
  import rv_plic_gateway_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic le_i,
  input  logic en_i,
  input  logic claim_i,
  input  logic complete_i,
  input  logic ovf_clr_i,
  output logic ip_o,
  output logic ia_o,
  output logic ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s;
  logic             s_q;
  logic             rise;
  logic             req;
  logic             take;
  logic             ovf_set;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  gw_state_e        state_q, state_d;

  // The synchronizer is optional: with zero stages the raw line is used
  // directly, which is only safe when the source is already in clk_i's domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw line through the synchronizer chain.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src_i;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A rise is seen in the same cycle the synchronized level first goes high,
  // so edge mode has the same latency as level mode.
  assign rise = s & ~s_q;

  // Edge mode keeps asking while stored edges remain or a fresh edge arrives;
  // level mode simply follows the synchronized line.
  assign req = le_i ? ((cnt_q != '0) | rise) : s;

  // Next-state logic of the handshake; 'take' consumes one stored edge
  // exactly when an edge-mode request is forwarded.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      GW_IDLE: begin
        if (en_i && req) begin
          state_d = GW_PENDING;
          take    = le_i;
        end
      end
      GW_PENDING: begin
        if (claim_i) begin
          state_d = GW_ACTIVE;
        end
      end
      GW_ACTIVE: begin
        if (complete_i) begin
          state_d = GW_IDLE;
        end
      end
      default: begin
        state_d = GW_IDLE;
      end
    endcase
  end

  // Edge counter: +rise -take, saturating at the top; an edge that cannot be
  // stored raises the overflow flag. Level mode keeps the counter empty so a
  // later switch to edge mode starts clean.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (!le_i) begin
      cnt_d = '0;
    end else if (rise && !take) begin
      if (cnt_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!rise && take) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  // State, edge history, counter and overflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ip_o  = (state_q == GW_PENDING);
  assign ia_o  = (state_q != GW_IDLE);
  assign ovf_o = ovf_q;

endmodule

// File: rtl/rv_plic_gateway_q.sv
// PLIC interrupt gateway: N_SOURCE independent channels, each converting a
// level or edge interrupt line into a single pending request per
// claim/complete round.
module rv_plic_gateway_q
  import rv_plic_gateway_pkg::*;
#(
  parameter int unsigned N_SOURCE    = DEF_N_SOURCE,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] en_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  input  logic [N_SOURCE-1:0] ovf_clr_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ia_o,
  output logic [N_SOURCE-1:0] ovf_o
);

  // Sources share nothing but the clock and reset, so each gets its own channel.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_chan
    rv_plic_gateway_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[i]),
      .le_i       (le_i[i]),
      .en_i       (en_i[i]),
      .claim_i    (claim_i[i]),
      .complete_i (complete_i[i]),
      .ovf_clr_i  (ovf_clr_i[i]),
      .ip_o       (ip_o[i]),
      .ia_o       (ia_o[i]),
      .ovf_o      (ovf_o[i])
    );
  end

endmodule

// File: tb/tb_rv_plic_gateway_q.sv
// Testbench for rv_plic_gateway_q: two instances (4-bit and 2-bit edge
// counters) share stimulus; expectations go into a scoreboard queue tagged
// with the cycle they apply to, and a monitor compares them mid-cycle.
module tb_rv_plic_gateway_q;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src, le, en, claim, complete, ovfClr;
  logic [N-1:0] ip4, ia4, ovf4;
  logic [N-1:0] ip2, ia2, ovf2;

  typedef struct {
    int           cyc;
    string        name;
    int           sel;
    logic [N-1:0] mask;
    logic [N-1:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  sbEntry_t monEntry;
  int cycleCount = 0;
  int total = 0;
  int bad = 0;

  rv_plic_gateway_q #(.N_SOURCE(N), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .en_i(en),
    .claim_i(claim), .complete_i(complete), .ovf_clr_i(ovfClr),
    .ip_o(ip4), .ia_o(ia4), .ovf_o(ovf4)
  );

  rv_plic_gateway_q #(.N_SOURCE(N), .CNT_W(2), .SYNC_STAGES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .en_i(en),
    .claim_i(claim), .complete_i(complete), .ovf_clr_i(ovfClr),
    .ip_o(ip2), .ia_o(ia2), .ovf_o(ovf2)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to tag scoreboard entries.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [N-1:0] bitm(int b);
    return N'(1) << b;
  endfunction

  // Selector: 0..2 = ip/ia/ovf of dut4, 3..5 = ip/ia/ovf of dut2.
  function automatic logic [N-1:0] pickOut(int sel);
    case (sel)
      0: return ip4;
      1: return ia4;
      2: return ovf4;
      3: return ip2;
      4: return ia2;
      default: return ovf2;
    endcase
  endfunction

  task automatic checkOutput(sbEntry_t e);
    logic [N-1:0] act;
    act = pickOut(e.sel) & e.mask;
    total++;
    if (act !== (e.exp & e.mask)) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", e.name, act, e.exp & e.mask, e.cyc);
    end
  endtask

  // Monitor: mid-cycle, pop every expectation due by now and compare it.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycleCount) begin
      monEntry = sb.pop_front();
      checkOutput(monEntry);
    end
  end

  task automatic expectOut(string name, int sel, logic [N-1:0] mask, logic [N-1:0] exp);
    sb.push_back('{cycleCount, name, sel, mask, exp});
  endtask

  task automatic applyStimulus(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse on a source, then one low cycle.
  task automatic pulseSrc(int b);
    src[b] = 1'b1;
    applyStimulus(1);
    src[b] = 1'b0;
    applyStimulus(1);
  endtask

  task automatic claimPulse(int b);
    claim[b] = 1'b1;
    applyStimulus(1);
    claim[b] = 1'b0;
  endtask

  task automatic completePulse(int b);
    complete[b] = 1'b1;
    applyStimulus(1);
    complete[b] = 1'b0;
  endtask

  // Complete service from ACTIVE, check the return to IDLE, then check
  // whether a stored edge re-raises ip on the following cycle.
  task automatic completeAndCheck(string name, int b, int base, logic expIp);
    completePulse(b);
    expectOut({name, " idle"}, base + 1, bitm(b), '0);
    applyStimulus(1);
    expectOut({name, " ip"}, base, bitm(b), expIp ? bitm(b) : '0);
  endtask

  // Overall watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    src = '0;
    le = 8'b0011_1110;
    en = 8'b1111_0111;
    claim = '0;
    complete = '0;
    ovfClr = '0;
    applyStimulus(2);
    expectOut("reset ip4", 0, '1, '0);
    expectOut("reset ia4", 1, '1, '0);
    expectOut("reset ovf4", 2, '1, '0);
    expectOut("reset ip2", 3, '1, '0);
    rst = 1'b0;
    applyStimulus(1);

    // Level source 0: ip three edges after src rises, latched after src drops.
    src[0] = 1'b1;
    applyStimulus(2);
    expectOut("lvl early ip", 0, bitm(0), '0);
    applyStimulus(1);
    expectOut("lvl ip", 0, bitm(0), bitm(0));
    expectOut("lvl ia", 1, bitm(0), bitm(0));
    claimPulse(0);
    expectOut("lvl claim ip", 0, bitm(0), '0);
    expectOut("lvl claim ia", 1, bitm(0), bitm(0));
    completePulse(0);
    expectOut("lvl complete ia", 1, bitm(0), '0);
    applyStimulus(1);
    expectOut("lvl reenter ip", 0, bitm(0), bitm(0));
    src[0] = 1'b0;
    applyStimulus(4);
    expectOut("lvl latched ip", 0, bitm(0), bitm(0));
    claimPulse(0);
    completePulse(0);
    applyStimulus(2);
    expectOut("lvl done ip", 0, bitm(0), '0);
    expectOut("lvl done ia", 1, bitm(0), '0);

    // Edge source 1: three edges stored while ACTIVE give three more rounds.
    pulseSrc(1);
    applyStimulus(1);
    expectOut("edge pend", 0, bitm(1), bitm(1));
    claimPulse(1);
    repeat (3) pulseSrc(1);
    applyStimulus(1);
    expectOut("edge active ip", 0, bitm(1), '0);
    expectOut("edge active ia", 1, bitm(1), bitm(1));
    completeAndCheck("edge r1", 1, 0, 1'b1);
    claimPulse(1);
    completeAndCheck("edge r2", 1, 0, 1'b1);
    claimPulse(1);
    completeAndCheck("edge r3", 1, 0, 1'b1);
    claimPulse(1);
    completeAndCheck("edge r4", 1, 0, 1'b0);
    applyStimulus(3);
    expectOut("edge stays idle", 0, bitm(1), '0);

    // Source 2 on the 2-bit counter: overflow, set beats clear, plain clear.
    pulseSrc(2);
    applyStimulus(1);
    expectOut("ovf pend", 3, bitm(2), bitm(2));
    claimPulse(2);
    repeat (5) pulseSrc(2);
    applyStimulus(1);
    expectOut("ovf set cnt2", 5, bitm(2), bitm(2));
    expectOut("ovf none cnt4", 2, bitm(2), '0);
    src[2] = 1'b1;
    applyStimulus(1);
    src[2] = 1'b0;
    applyStimulus(1);
    ovfClr[2] = 1'b1;
    applyStimulus(1);
    ovfClr[2] = 1'b0;
    expectOut("ovf set wins clr", 5, bitm(2), bitm(2));
    ovfClr[2] = 1'b1;
    applyStimulus(1);
    ovfClr[2] = 1'b0;
    expectOut("ovf cleared", 5, bitm(2), '0);
    completeAndCheck("sat r1", 2, 3, 1'b1);
    claimPulse(2);
    completeAndCheck("sat r2", 2, 3, 1'b1);
    claimPulse(2);
    completeAndCheck("sat r3", 2, 3, 1'b1);
    claimPulse(2);
    completeAndCheck("sat r4", 2, 3, 1'b0);

    // Source 4: claim+complete together in PENDING; rise with take stores nothing.
    pulseSrc(4);
    applyStimulus(1);
    expectOut("same pend", 0, bitm(4), bitm(4));
    claim[4] = 1'b1;
    complete[4] = 1'b1;
    applyStimulus(1);
    claim[4] = 1'b0;
    complete[4] = 1'b0;
    expectOut("same ip", 0, bitm(4), '0);
    expectOut("same ia", 1, bitm(4), bitm(4));
    completeAndCheck("take rise", 4, 0, 1'b0);

    // Source 3: disabled edges are counted, released one per round.
    pulseSrc(3);
    pulseSrc(3);
    applyStimulus(1);
    expectOut("gate ip", 0, bitm(3), '0);
    expectOut("gate ia", 1, bitm(3), '0);
    en[3] = 1'b1;
    applyStimulus(1);
    expectOut("gate enable ip", 0, bitm(3), bitm(3));
    claimPulse(3);
    completeAndCheck("gate r1", 3, 0, 1'b1);
    claimPulse(3);
    completeAndCheck("gate r2", 3, 0, 1'b0);

    // Source 5: reset while ACTIVE with five stored edges.
    pulseSrc(5);
    applyStimulus(1);
    claimPulse(5);
    expectOut("rst pre ia", 1, bitm(5), bitm(5));
    repeat (5) pulseSrc(5);
    applyStimulus(1);
    expectOut("rst pre ovf2", 5, bitm(5), bitm(5));
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    expectOut("midrst ip4", 0, '1, '0);
    expectOut("midrst ia4", 1, '1, '0);
    expectOut("midrst ovf4", 2, '1, '0);
    expectOut("midrst ip2", 3, '1, '0);
    expectOut("midrst ia2", 4, '1, '0);
    expectOut("midrst ovf2", 5, '1, '0);
    pulseSrc(5);
    applyStimulus(1);
    expectOut("post rst pend", 0, bitm(5), bitm(5));
    claimPulse(5);
    completeAndCheck("post rst", 5, 0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    applyStimulus(2);
    for (int g = 0; g < 20 && sb.size() > 0; g++) applyStimulus(1);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
